// File: rtl/alu_result_stage_pkg.sv
// Shared types and constants for the ALU result stage and its BCD corrector.
package alu_result_stage_pkg;

   // IDLE accepts new adder results; ADJ is the single decimal-correction cycle.
   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StAdj  = 1'b1
   } state_e;

   localparam logic [7:0] BCD_LO_ADJ = 8'h06;
   localparam logic [7:0] BCD_HI_ADJ = 8'h60;
   localparam logic [7:0] BCD_MAX    = 8'h99;

endpackage

// File: rtl/alu_result_stage_bcd_adjust.sv
// Combinational 65C02 BCD correction of a binary adder result.
module bcd_adjust
   import alu_result_stage_pkg::*;
(
   input  logic [7:0] sum,
   input  logic       co,
   input  logic       hc,
   input  logic       sub,
   output logic [7:0] adj,
   output logic       c
);

   logic lo_adj;
   logic hi_adj;

   // Addition corrects nibbles that overflowed or exceed 9; subtraction corrects on borrow.
   always_comb begin
      lo_adj = hc | (sum[3:0] > 4'd9);
      hi_adj = co | (sum > BCD_MAX);
      adj    = sum;
      c      = co;
      if (sub) begin
         adj = sum - (hc ? 8'h00 : BCD_LO_ADJ) - (co ? 8'h00 : BCD_HI_ADJ);
         c   = co;
      end else begin
         adj = sum + (lo_adj ? BCD_LO_ADJ : 8'h00) + (hi_adj ? BCD_HI_ADJ : 8'h00);
         c   = hi_adj;
      end
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result/flag stage after the ALU adder, with optional one-cycle BCD correction.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter bit DEC_ENABLE = 1'b1
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] sum,
   input  logic       co,
   input  logic       dec,
   input  logic       sub,
   output logic       out_valid,
   output logic [7:0] result,
   output logic       flag_n,
   output logic       flag_z,
   output logic       flag_c,
   output logic       flag_v
);

   state_e     state_q, state_d;
   logic [7:0] sum_q, sum_d;
   logic       co_q, co_d;
   logic       hc_q, hc_d;
   logic       v_q, v_d;
   logic       sub_q, sub_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] result_q, result_d;
   logic       n_q, n_d, z_q, z_d, c_q, c_d, fv_q, fv_d;

   logic       accept;
   logic       in_hc;
   logic       in_v;
   logic [7:0] adj;
   logic       adj_c;

   assign in_ready = (state_q == StIdle);
   assign accept   = in_valid && in_ready;
   // Carry into bit 4 recovered from the operands and sum.
   assign in_hc    = a[4] ^ b[4] ^ sum[4];
   assign in_v     = (a[7] ~^ b[7]) & (a[7] ^ sum[7]);

   bcd_adjust u_bcd_adjust (
      .sum (sum_q),
      .co  (co_q),
      .hc  (hc_q),
      .sub (sub_q),
      .adj (adj),
      .c   (adj_c)
   );

   // Next-state, operand capture and result/flag update.
   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      co_d        = co_q;
      hc_d        = hc_q;
      v_d         = v_q;
      sub_d       = sub_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      n_d         = n_q;
      z_d         = z_q;
      c_d         = c_q;
      fv_d        = fv_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (DEC_ENABLE && dec) begin
                  sum_d   = sum;
                  co_d    = co;
                  hc_d    = in_hc;
                  v_d     = in_v;
                  sub_d   = sub;
                  state_d = StAdj;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = sum;
                  n_d         = sum[7];
                  z_d         = (sum == 8'h00);
                  c_d         = co;
                  fv_d        = in_v;
               end
            end
         end
         StAdj: begin
            // N/Z follow the corrected value; V stays the binary overflow.
            out_valid_d = 1'b1;
            result_d    = adj;
            n_d         = adj[7];
            z_d         = (adj == 8'h00);
            c_d         = adj_c;
            fv_d        = v_q;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q     <= StIdle;
         sum_q       <= 8'h00;
         co_q        <= 1'b0;
         hc_q        <= 1'b0;
         v_q         <= 1'b0;
         sub_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= 8'h00;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         c_q         <= 1'b0;
         fv_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         co_q        <= co_d;
         hc_q        <= hc_d;
         v_q         <= v_d;
         sub_q       <= sub_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         n_q         <= n_d;
         z_q         <= z_d;
         c_q         <= c_d;
         fv_q        <= fv_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag_n    = n_q;
   assign flag_z    = z_q;
   assign flag_c    = c_q;
   assign flag_v    = fv_q;

endmodule
